// File: rtl/fast_circle_fetch.sv
// Raster-scans FAST candidate centres, reading each centre pixel plus its radius-3 Bresenham ring
// and handing the 17-pixel bundle downstream over valid/ready. Define FAST_ROI_EN for a region of interest.
module fast_circle_fetch #(
  parameter int X_MAX   = 64,
  parameter int Y_MAX   = 64,
  parameter int PIXEL_W = 8,
  parameter int BORDER  = 3
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       start,
  input  logic                       new_trans,
`ifdef FAST_ROI_EN
  input  logic [$clog2(X_MAX)-1:0]   roi_x0,
  input  logic [$clog2(X_MAX)-1:0]   roi_x1,
  input  logic [$clog2(Y_MAX)-1:0]   roi_y0,
  input  logic [$clog2(Y_MAX)-1:0]   roi_y1,
`endif
  output logic                       ren,
  output logic [$clog2(X_MAX)-1:0]   x_addr,
  output logic [$clog2(Y_MAX)-1:0]   y_addr,
  input  logic [PIXEL_W-1:0]         rdat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PIXEL_W-1:0]         center_pix,
  output logic [16*PIXEL_W-1:0]      ring_pix,
  output logic [$clog2(X_MAX)-1:0]   out_x,
  output logic [$clog2(Y_MAX)-1:0]   out_y,
  output logic                       busy,
  output logic                       done
);

  localparam int XW = $clog2(X_MAX);
  localparam int YW = $clog2(Y_MAX);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_ADVANCE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  // Ring offsets clockwise from twelve o'clock
  localparam int RING_DX [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  localparam int RING_DY [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  logic [2:0]    state_reg, state_next;
  logic [XW-1:0] cx_reg, cx_next;
  logic [YW-1:0] cy_reg, cy_next;
  logic [XW-1:0] x_lo_reg, x_lo_next, x_hi_reg, x_hi_next;
  logic [YW-1:0] y_lo_reg, y_lo_next, y_hi_reg, y_hi_next;
  logic [4:0]    k_reg, k_next;
  logic          rd_valid_reg;
  logic [4:0]    rd_idx_reg;

  int            lo_x, hi_x, lo_y, hi_y;
  logic          scan_empty;
  logic [3:0]    off_idx;
  int            dx, dy, ax, ay;

  logic [16:0][PIXEL_W-1:0] slots;

  always_comb begin
`ifdef FAST_ROI_EN
    lo_x = (int'(roi_x0) > BORDER) ? int'(roi_x0) : BORDER;
    hi_x = (int'(roi_x1) < X_MAX - 1 - BORDER) ? int'(roi_x1) : X_MAX - 1 - BORDER;
    lo_y = (int'(roi_y0) > BORDER) ? int'(roi_y0) : BORDER;
    hi_y = (int'(roi_y1) < Y_MAX - 1 - BORDER) ? int'(roi_y1) : Y_MAX - 1 - BORDER;
`else
    lo_x = BORDER;
    hi_x = X_MAX - 1 - BORDER;
    lo_y = BORDER;
    hi_y = Y_MAX - 1 - BORDER;
`endif
    scan_empty = (lo_x > hi_x) || (lo_y > hi_y);
  end

  // Read 0 is the centre; reads 1..16 walk the ring
  always_comb begin
    off_idx = 4'(k_reg - 5'd1);
    dx = 0;
    dy = 0;
    if (k_reg != 5'd0) begin
      dx = RING_DX[off_idx];
      dy = RING_DY[off_idx];
    end
    ax = int'(cx_reg) + dx;
    ay = int'(cy_reg) + dy;
  end

  assign ren       = (state_reg == S_FETCH);
  assign x_addr    = ren ? XW'(ax) : '0;
  assign y_addr    = ren ? YW'(ay) : '0;
  assign out_valid = (state_reg == S_PRESENT);
  assign busy      = (state_reg != S_IDLE);
  assign done      = (state_reg == S_DONE);
  assign out_x     = out_valid ? cx_reg : '0;
  assign out_y     = out_valid ? cy_reg : '0;

  always_comb begin
    state_next = state_reg;
    cx_next    = cx_reg;
    cy_next    = cy_reg;
    k_next     = k_reg;
    x_lo_next  = x_lo_reg;
    x_hi_next  = x_hi_reg;
    y_lo_next  = y_lo_reg;
    y_hi_next  = y_hi_reg;
    if (new_trans) begin
      state_next = S_IDLE;
      cx_next    = '0;
      cy_next    = '0;
      k_next     = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            x_lo_next  = XW'(lo_x);
            x_hi_next  = XW'(hi_x);
            y_lo_next  = YW'(lo_y);
            y_hi_next  = YW'(hi_y);
            cx_next    = XW'(lo_x);
            cy_next    = YW'(lo_y);
            k_next     = '0;
            state_next = scan_empty ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          if (k_reg == 5'd16) begin
            k_next     = '0;
            state_next = S_DRAIN;
          end else begin
            k_next = k_reg + 5'd1;
          end
        end
        S_DRAIN: state_next = S_PRESENT;
        S_PRESENT: begin
          if (out_ready) state_next = S_ADVANCE;
        end
        S_ADVANCE: begin
          if (cx_reg == x_hi_reg) begin
            cx_next = x_lo_reg;
            if (cy_reg == y_hi_reg) begin
              state_next = S_DONE;
            end else begin
              cy_next    = cy_reg + YW'(1);
              state_next = S_FETCH;
            end
          end else begin
            cx_next    = cx_reg + XW'(1);
            state_next = S_FETCH;
          end
        end
        S_DONE: begin
          cx_next    = '0;
          cy_next    = '0;
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= S_IDLE;
      cx_reg    <= '0;
      cy_reg    <= '0;
      k_reg     <= '0;
      x_lo_reg  <= '0;
      x_hi_reg  <= '0;
      y_lo_reg  <= '0;
      y_hi_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cx_reg    <= cx_next;
      cy_reg    <= cy_next;
      k_reg     <= k_next;
      x_lo_reg  <= x_lo_next;
      x_hi_reg  <= x_hi_next;
      y_lo_reg  <= y_lo_next;
      y_hi_reg  <= y_hi_next;
    end
  end

  // SRAM data lags ren by a cycle, so the read index travels with it
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_valid_reg <= 1'b0;
      rd_idx_reg   <= '0;
    end else if (new_trans) begin
      rd_valid_reg <= 1'b0;
      rd_idx_reg   <= '0;
    end else begin
      rd_valid_reg <= ren;
      rd_idx_reg   <= k_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 17; gi++) begin : g_slot
      logic [PIXEL_W-1:0] slot_reg;
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          slot_reg <= '0;
        end else if (new_trans) begin
          slot_reg <= '0;
        end else if (rd_valid_reg && (rd_idx_reg == 5'(gi))) begin
          slot_reg <= rdat;
        end
      end
      assign slots[gi] = slot_reg;
    end
  endgenerate

  assign center_pix = slots[0];
  assign ring_pix   = slots[16:1];

endmodule

// File: tb/tb_fast_circle_fetch.sv
// Scoreboard bench for fast_circle_fetch: a pixel-level reference model queues expected bundles at each start
// and a negedge monitor pops and compares on every handshake.
module tb_fast_circle_fetch;

  localparam int X  = 9;
  localparam int Y  = 8;
  localparam int W  = 8;
  localparam int B  = 3;
  localparam int XW = $clog2(X);
  localparam int YW = $clog2(Y);
  localparam int RDX [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  localparam int RDY [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start = 1'b0;
  logic new_trans = 1'b0;
  logic out_ready = 1'b0;
  logic ren;
  logic [XW-1:0] x_addr;
  logic [YW-1:0] y_addr;
  logic [W-1:0] rdat = '0;
  logic out_valid;
  logic [W-1:0] center_pix;
  logic [16*W-1:0] ring_pix;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic busy;
  logic done;
`ifdef FAST_ROI_EN
  logic [XW-1:0] roi_x0 = '0;
  logic [XW-1:0] roi_x1 = '1;
  logic [YW-1:0] roi_y0 = '0;
  logic [YW-1:0] roi_y1 = '1;
`endif

  // Degenerate 6-column frame: too narrow for any centre
  logic s_start = 1'b0;
  logic s_ren, s_out_valid, s_busy, s_done;
  logic [2:0] s_x_addr, s_out_x;
  logic [2:0] s_y_addr, s_out_y;
  logic [W-1:0] s_center;
  logic [16*W-1:0] s_ring;

  always #5 clk = ~clk;

  fast_circle_fetch #(.X_MAX(X), .Y_MAX(Y), .PIXEL_W(W), .BORDER(B)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .new_trans(new_trans),
`ifdef FAST_ROI_EN
    .roi_x0(roi_x0), .roi_x1(roi_x1), .roi_y0(roi_y0), .roi_y1(roi_y1),
`endif
    .ren(ren), .x_addr(x_addr), .y_addr(y_addr), .rdat(rdat),
    .out_valid(out_valid), .out_ready(out_ready), .center_pix(center_pix),
    .ring_pix(ring_pix), .out_x(out_x), .out_y(out_y), .busy(busy), .done(done)
  );

  fast_circle_fetch #(.X_MAX(6), .Y_MAX(8), .PIXEL_W(W), .BORDER(B)) dut_small (
    .clk(clk), .n_rst(n_rst), .start(s_start), .new_trans(1'b0),
`ifdef FAST_ROI_EN
    .roi_x0(3'd0), .roi_x1(3'd7), .roi_y0(3'd0), .roi_y1(3'd7),
`endif
    .ren(s_ren), .x_addr(s_x_addr), .y_addr(s_y_addr), .rdat(8'h5a),
    .out_valid(s_out_valid), .out_ready(1'b1), .center_pix(s_center),
    .ring_pix(s_ring), .out_x(s_out_x), .out_y(s_out_y), .busy(s_busy), .done(s_done)
  );

  // Image SRAM with one-cycle registered read
  logic [W-1:0] img [Y][X];
  always @(posedge clk) begin
    if (ren) rdat <= img[y_addr][x_addr];
  end

  typedef struct {
    int           x;
    int           y;
    logic [W-1:0] c;
    logic [127:0] ring;
  } bundle_t;
  bundle_t exp_q [$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int trig_cyc = 0;
  bit trig_first = 1'b0;
  int done_cnt = 0;
  int acc_cnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_pattern();
    for (int y = 0; y < Y; y++)
      for (int x = 0; x < X; x++) img[y][x] = W'(16 * y + x);
  endtask

  task automatic fill_random();
    for (int y = 0; y < Y; y++)
      for (int x = 0; x < X; x++) img[y][x] = W'($urandom);
  endtask

  // Reference model: every centre inside the clamped window, row-major, x fastest
  task automatic push_scan();
    int xl, xh, yl, yh;
    bundle_t b;
    xl = B;
    xh = X - 1 - B;
    yl = B;
    yh = Y - 1 - B;
`ifdef FAST_ROI_EN
    if (int'(roi_x0) > xl) xl = int'(roi_x0);
    if (int'(roi_x1) < xh) xh = int'(roi_x1);
    if (int'(roi_y0) > yl) yl = int'(roi_y0);
    if (int'(roi_y1) < yh) yh = int'(roi_y1);
`endif
    for (int y = yl; y <= yh; y++) begin
      for (int x = xl; x <= xh; x++) begin
        b.x = x;
        b.y = y;
        b.c = img[y][x];
        b.ring = '0;
        for (int i = 0; i < 16; i++) b.ring[i*W +: W] = img[y + RDY[i]][x + RDX[i]];
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic do_start();
    push_scan();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input bit rnd, input string nm);
    int n = 0;
    while (!done && n < max) begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    chk(nm, 128'(done), 128'(1));
    out_ready = 1'b1;
    tick();
  endtask

  task automatic wait_valid(input int max, input string nm);
    int n = 0;
    while (!out_valid && n < max) begin
      tick();
      n++;
    end
    chk(nm, 128'(out_valid), 128'(1));
  endtask

  // Monitor: handshakes, hold-while-stalled, latency and done timing
  initial begin : monitor
    logic          prev_valid;
    logic          prev_acc;
    logic [14:0]   prev_hdr;
    logic [127:0]  prev_ring;
    bundle_t       e;
    prev_valid = 1'b0;
    prev_acc   = 1'b0;
    prev_hdr   = '0;
    prev_ring  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!n_rst) begin
        prev_valid = 1'b0;
      end else begin
        if (start && !busy && !new_trans) begin
          trig_cyc   = cyc;
          trig_first = 1'b1;
        end
        if (out_valid && !prev_valid)
          chk("valid_latency", 128'(cyc - trig_cyc), 128'(trig_first ? 19 : 20));
        if (out_valid && prev_valid && !prev_acc) begin
          chk("hold_header", 128'({out_x, out_y, center_pix}), 128'(prev_hdr));
          chk("hold_ring", ring_pix, prev_ring);
          chk("hold_ren", 128'(ren), 128'(0));
        end
        if (out_valid && out_ready) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            chk("bundle_extra", 128'(exp_q.size()), 128'(1));
          end else begin
            e = exp_q.pop_front();
            $display("bundle (%0d,%0d) center=%h ring=%h", out_x, out_y, center_pix, ring_pix);
            chk("out_x", 128'(out_x), 128'(e.x));
            chk("out_y", 128'(out_y), 128'(e.y));
            chk("center_pix", 128'(center_pix), 128'(e.c));
            chk("ring_pix", ring_pix, e.ring);
          end
          trig_cyc   = cyc;
          trig_first = 1'b0;
        end
        if (done) begin
          done_cnt++;
          chk("done_timing", 128'(cyc - trig_cyc), 128'(trig_first ? 1 : 2));
          chk("done_queue_empty", 128'(exp_q.size()), 128'(0));
        end
        prev_valid = out_valid;
        prev_acc   = out_valid && out_ready;
        prev_hdr   = {out_x, out_y, center_pix};
        prev_ring  = ring_pix;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int a0, d0, n;
    bit s_ren_seen;
    int s_done_n, s_done_at;

    // Reset state
    repeat (3) tick();
    chk("rst_ctrl", 128'({ren, out_valid, busy, done, x_addr, y_addr, out_x, out_y, center_pix}), 128'(0));
    chk("rst_ring", ring_pix, 128'(0));
    chk("rst_small", 128'({s_ren, s_out_valid, s_busy, s_done}), 128'(0));
    n_rst = 1'b1;
    tick();

    // Known pattern, first centre at (3,3)
    fill_pattern();
    out_ready = 1'b1;
    a0 = acc_cnt;
    d0 = done_cnt;
    do_start();
    wait_valid(40, "pattern_valid_timeout");
    chk("pat_center", 128'(center_pix), 128'(8'h33));
    chk("pat_ring0", 128'(ring_pix[0*W +: W]), 128'(8'h03));
    chk("pat_ring4", 128'(ring_pix[4*W +: W]), 128'(8'h36));
    chk("pat_ring8", 128'(ring_pix[8*W +: W]), 128'(8'h63));
    chk("pat_ring12", 128'(ring_pix[12*W +: W]), 128'(8'h30));
    chk("pat_xy", 128'({out_x, out_y}), 128'({4'd3, 3'd3}));
    wait_done(300, 1'b0, "pattern_done_timeout");
    repeat (2) tick();
    chk("pattern_bundles", 128'(acc_cnt - a0), 128'(6));
    chk("pattern_done_once", 128'(done_cnt - d0), 128'(1));
    chk("pattern_idle", 128'(busy), 128'(0));

    // Random image, random back-pressure, stray start while busy
    fill_random();
    a0 = acc_cnt;
    do_start();
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(3000, 1'b1, "random_done_timeout");
    chk("random_bundles", 128'(acc_cnt - a0), 128'(6));

    // Stall 10 cycles in PRESENT, then exactly one handshake
    fill_random();
    out_ready = 1'b0;
    do_start();
    wait_valid(40, "stall_valid_timeout");
    a0 = acc_cnt;
    repeat (10) tick();
    chk("stall_no_accept", 128'(acc_cnt - a0), 128'(0));
    chk("stall_ren", 128'(ren), 128'(0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    chk("stall_one_accept", 128'(acc_cnt - a0), 128'(1));

    // Asynchronous reset while presenting the next bundle
    wait_valid(40, "reset_valid_timeout");
    tick();
    #2;
    n_rst = 1'b0;
    #1;
    chk("areset_ctrl", 128'({ren, out_valid, busy, done, x_addr, y_addr, out_x, out_y, center_pix}), 128'(0));
    chk("areset_ring", ring_pix, 128'(0));
    exp_q.delete();
    tick();
    n_rst = 1'b1;
    tick();

    // Abort during the 8th FETCH cycle, then rescan
    fill_random();
    out_ready = 1'b1;
    do_start();
    n = 1;
    while (n < 8) begin
      tick();
      n++;
    end
    chk("abort_in_fetch", 128'(ren), 128'(1));
    new_trans = 1'b1;
    tick();
    new_trans = 1'b0;
    chk("abort_ren", 128'(ren), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_outputs", 128'({out_valid, out_x, out_y, center_pix}), 128'(0));
    exp_q.delete();
    tick();
    a0 = acc_cnt;
    do_start();
    wait_done(300, 1'b0, "rescan_done_timeout");
    chk("rescan_bundles", 128'(acc_cnt - a0), 128'(6));

`ifdef FAST_ROI_EN
    // ROI clipped to one row
    roi_x0 = 4'd0;
    roi_x1 = 4'd4;
    roi_y0 = 3'd4;
    roi_y1 = 3'd4;
    a0 = acc_cnt;
    do_start();
    wait_done(200, 1'b0, "roi_done_timeout");
    chk("roi_bundles", 128'(acc_cnt - a0), 128'(2));
    // Empty ROI
    roi_x0 = 4'd7;
    roi_x1 = 4'd6;
    roi_y0 = 3'd2;
    roi_y1 = 3'd2;
    a0 = acc_cnt;
    d0 = done_cnt;
    do_start();
    wait_done(5, 1'b0, "roi_empty_timeout");
    chk("roi_empty_bundles", 128'(acc_cnt - a0), 128'(0));
    chk("roi_empty_done", 128'(done_cnt - d0), 128'(1));
    roi_x0 = '0;
    roi_x1 = '1;
    roi_y0 = '0;
    roi_y1 = '1;
`endif

    // Frame narrower than 2*BORDER+1
    s_ren_seen = 1'b0;
    s_done_n = 0;
    s_done_at = 0;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (s_ren) s_ren_seen = 1'b1;
      if (s_done) begin
        s_done_n++;
        if (s_done_at == 0) s_done_at = i;
      end
      tick();
    end
    chk("small_no_ren", 128'(s_ren_seen), 128'(0));
    chk("small_done_once", 128'(s_done_n), 128'(1));
    chk("small_done_prompt", 128'(s_done_at >= 1 && s_done_at <= 2), 128'(1));
    chk("small_idle", 128'(s_busy), 128'(0));

    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
